y86_fetch_unit: RTL
===================

Name: y86_fetch_unit

Overview:
- Fetch stage of the sequential Y86-64 core. It consumes the PC produced by the PC-update stage and fetches the instruction byte-serially over a req/ack byte-wide instruction-memory port.
- It assembles and splits the instruction into icode, ifun, rA, rB, valC and valP, then hands the result to decode with a valid/ready handshake.
- It is the reader side of the PC register written by the PC-update stage.

Parameters:
- n, 64, address/data width of PC, valC, valP.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_in  input  n  PC to fetch from.
- pc_valid  input  1  pc_in valid.
- pc_ready  output  1  unit idle and accepting a PC.
- mem_req  output  1  byte read request.
- mem_addr  output  n  byte address of the request.
- mem_rdata  input  8  returned byte, valid when mem_ack=1.
- mem_ack  input  1  read complete, 1-cycle pulse.
- mem_err  input  1  address error, sampled with mem_ack.
- instr_valid  output  1  decoded instruction available.
- instr_ready  input  1  decode accepts the instruction.
- icode  output  4  instruction code.
- ifun  output  4  function code.
- rA  output  4  register A; 4'hF if the instruction has no register byte.
- rB  output  4  register B; 4'hF if the instruction has no register byte.
- valC  output  n  constant, little-endian assembled; 0 if the instruction has none.
- valP  output  n  pc_in + instruction length (mod 2^n).
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - pc_ready=1, mem_req=0, mem_addr=0, instr_valid=0.
  - icode=0, ifun=0, rA=F, rB=F, valC=0, valP=0, stat=1.
- Reset mid-fetch aborts the fetch. A late mem_ack after reset is ignored.
- States:
  - IDLE: pc_ready=1. On pc_valid, latch PC, set byte index k=0, go to REQ.
  - REQ: mem_req=1, mem_addr=PC+k (wraps mod 2^n). Both are held stable until mem_ack. On mem_ack, the byte is stored; then the unit either moves to the next byte (k+1, mem_req remains 1) or goes to DONE.
  - DONE: instr_valid=1, all outputs held stable. On instr_ready, go to IDLE; instr_valid drops the next cycle.
- pc_valid is ignored outside IDLE. The PC is captured only on the IDLE->REQ edge.
- Byte 0 supplies icode and ifun (byte[7:4] and byte[3:0]).
- Instruction lengths by icode:
  - 1 byte: 0, 1, 9.
  - 2 bytes: 2, 6, A, B (register byte only).
  - 9 bytes: 7, 8 (valC from bytes 1-8).
  - 10 bytes: 3, 4, 5 (register byte 1, valC from bytes 2-9).
- Register byte: rA=byte[7:4], rB=byte[3:0].
- valC assembly: byte j of the constant lands in valC[8j+7:8j].
- icode>B: stat=INS, length 1, no further reads, go to DONE.
- icode=0: stat=HLT, length 1.
- mem_err on any ack: stat=ADR, stop reading immediately, go to DONE.
  - Fields not yet fetched keep their defaults (rA/rB=F, valC=0).
  - valP = PC + full decoded length if byte 0 was received, else PC+1.
- Latency: minimum (length + 1) cycles from pc_valid to instr_valid, given a zero-wait ack. One request is outstanding at a time.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Zero-wait memory holding 30 F2 at PC=0x100 (irmovq) with constant bytes 78 56 34 12 00 00 00 00 -> icode=3, ifun=0, rA=F, rB=2, valC=0x12345678, valP=0x10A, stat=1; 10 requests to addresses 0x100-0x109.
- PC=0x40, byte 0x90 (ret) -> one request, rA=rB=F, valC=0, valP=0x41, instr_valid 2 cycles after pc_valid.
- PC=0x0, bytes 73 00 02 00 00 00 00 00 00 (je) with 3-cycle ack delay -> mem_addr is held stable during each wait, valC=0x200, valP=9, stat=1.
- Byte 0xC0 -> stat=INS, valP=PC+1, single read. Byte 0x00 -> stat=HLT.
- irmovq at PC=0x200 with mem_err on byte 4 -> stat=ADR, valP=0x20A, mem_req low from the next cycle, valC=0.
- Hold instr_ready=0 for 5 cycles -> outputs stable and pc_valid ignored. Assert rst_n=0 during REQ -> outputs return to reset values asynchronously, pc_ready=1 after release.

Source files
------------

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: reads an instruction byte-serially from instruction memory,
// splits it into icode/ifun/rA/rB/valC/valP/stat and hands it to decode.
module y86_fetch_unit #(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] pc_in,
  input  logic         pc_valid,
  output logic         pc_ready,
  output logic         mem_req,
  output logic [n-1:0] mem_addr,
  input  logic [7:0]   mem_rdata,
  input  logic         mem_ack,
  input  logic         mem_err,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   rA,
  output logic [3:0]   rB,
  output logic [n-1:0] valC,
  output logic [n-1:0] valP,
  output logic [2:0]   stat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    logic [3:0] len;
    case (ic)
      4'h0, 4'h1, 4'h9:        len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
      4'h7, 4'h8:              len = 4'd9;
      4'h3, 4'h4, 4'h5:        len = 4'd10;
      default:                 len = 4'd1;
    endcase
    return len;
  endfunction

  function automatic logic has_regbyte(input logic [3:0] ic);
    logic r;
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  logic [1:0]   state_r;
  logic [n-1:0] pc_r;
  logic [3:0]   k_r;
  logic [3:0]   len_r;
  logic         pc_ready_r;
  logic         mem_req_r;
  logic [n-1:0] mem_addr_r;
  logic         instr_valid_r;
  logic [3:0]   icode_r;
  logic [3:0]   ifun_r;
  logic [3:0]   ra_r;
  logic [3:0]   rb_r;
  logic [n-1:0] valc_r;
  logic [n-1:0] valp_r;
  logic [2:0]   stat_r;

  logic         ack_s;
  logic [3:0]   ic_s;
  logic         fin_s;
  logic [2:0]   fin_stat_s;
  logic [3:0]   fin_len_s;
  logic [2:0]   valc_idx_s;

  // Classify the byte being acknowledged: does the fetch end here, and with what status/length.
  always_comb begin
    ack_s      = (state_r == ST_REQ) && mem_req_r && mem_ack;
    ic_s       = mem_rdata[7:4];
    fin_s      = 1'b0;
    fin_stat_s = STAT_AOK;
    fin_len_s  = len_r;
    valc_idx_s = 3'(k_r - (has_regbyte(icode_r) ? 4'd2 : 4'd1));
    if (!ack_s) begin
      fin_s = 1'b0;
    end else if (mem_err) begin
      fin_s      = 1'b1;
      fin_stat_s = STAT_ADR;
      fin_len_s  = (k_r == 4'd0) ? 4'd1 : len_r;
    end else if (k_r == 4'd0) begin
      if (ic_s > 4'hB) begin
        fin_s      = 1'b1;
        fin_stat_s = STAT_INS;
        fin_len_s  = 4'd1;
      end else if (ic_s == 4'h0) begin
        fin_s      = 1'b1;
        fin_stat_s = STAT_HLT;
        fin_len_s  = 4'd1;
      end else begin
        fin_len_s = instr_len(ic_s);
        fin_s     = (instr_len(ic_s) == 4'd1);
      end
    end else begin
      fin_s = (k_r == (len_r - 4'd1));
    end
  end

  // Fetch sequencer plus the registered instruction fields it fills in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= {n{1'b0}};
      k_r           <= 4'd0;
      len_r         <= 4'd1;
      pc_ready_r    <= 1'b1;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= {n{1'b0}};
      instr_valid_r <= 1'b0;
      icode_r       <= 4'h0;
      ifun_r        <= 4'h0;
      ra_r          <= 4'hF;
      rb_r          <= 4'hF;
      valc_r        <= {n{1'b0}};
      valp_r        <= {n{1'b0}};
      stat_r        <= STAT_AOK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pc_valid) begin
            pc_r       <= pc_in;
            k_r        <= 4'd0;
            len_r      <= 4'd1;
            mem_addr_r <= pc_in;
            mem_req_r  <= 1'b1;
            pc_ready_r <= 1'b0;
            icode_r    <= 4'h0;
            ifun_r     <= 4'h0;
            ra_r       <= 4'hF;
            rb_r       <= 4'hF;
            valc_r     <= {n{1'b0}};
            stat_r     <= STAT_AOK;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s && !mem_err) begin
            if (k_r == 4'd0) begin
              icode_r <= mem_rdata[7:4];
              ifun_r  <= mem_rdata[3:0];
              len_r   <= instr_len(ic_s);
            end else if (has_regbyte(icode_r) && (k_r == 4'd1)) begin
              ra_r <= mem_rdata[7:4];
              rb_r <= mem_rdata[3:0];
            end else begin
              valc_r[{valc_idx_s, 3'b000} +: 8] <= mem_rdata;
            end
          end
          if (fin_s) begin
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b1;
            stat_r        <= fin_stat_s;
            valp_r        <= pc_r + {{(n-4){1'b0}}, fin_len_s};
            state_r       <= ST_DONE;
          end else if (ack_s) begin
            k_r        <= k_r + 4'd1;
            mem_addr_r <= mem_addr_r + {{(n-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (instr_ready) begin
            instr_valid_r <= 1'b0;
            pc_ready_r    <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          mem_req_r     <= 1'b0;
          instr_valid_r <= 1'b0;
          pc_ready_r    <= 1'b1;
        end
      endcase
    end
  end

  assign pc_ready    = pc_ready_r;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = instr_valid_r;
  assign icode       = icode_r;
  assign ifun        = ifun_r;
  assign rA          = ra_r;
  assign rB          = rb_r;
  assign valC        = valc_r;
  assign valP        = valp_r;
  assign stat        = stat_r;

endmodule
